traffic_light_controller: RTL and testbench

- Cycle-accurate FSM sequencing a two-road intersection (north-south main road NS, east-west side road EW) with pedestrian phase and emergency override.
- Runs on the project clock and advances phase timers only on a one-cycle `tick` strobe, so phase lengths are in ticks.
- Drives lamp outputs for the signal display; a top-level wrapper provides the `tick` divider.

---
 rtl/traffic_light_controller_if.sv | 23 ++
 rtl/traffic_light_controller.sv | 182 ++++++++++++++++++
 tb/tb_traffic_light_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_controller_if.sv
// Signal bundle between the intersection controller and its environment.
// The master side drives timebase and demand inputs; the slave side drives lamps and status.
interface traffic_light_controller_if;
    logic       tick;
    logic       sensor_ew;
    logic       ped_req;
    logic       emerg;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] state_o;

    modport master (
        output tick, sensor_ew, ped_req, emerg,
        input  ns_light, ew_light, walk, ped_pending, state_o
    );

    modport slave (
        input  tick, sensor_ew, ped_req, emerg,
        output ns_light, ew_light, walk, ped_pending, state_o
    );
endinterface

// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer with pedestrian phase and emergency override.
// Phase timers advance only on tick, so every phase length is counted in ticks.
//
//  state     | meaning
//  NS_GREEN  | main road green, held until demand after minimum green
//  NS_YELLOW | main road yellow
//  ALLRED_A  | clearance before side road or pedestrian phase
//  EW_GREEN  | side road green, fixed length
//  EW_YELLOW | side road yellow
//  ALLRED_B  | clearance before main road; reset state
//  PED_WALK  | both roads red, walk lamp lit
//  EMERG     | both roads red while the emergency input is held
module traffic_light_controller #(
    parameter int T_GREEN_NS = 20,
    parameter int T_GREEN_EW = 10,
    parameter int T_YELLOW   = 4,
    parameter int T_ALLRED   = 2,
    parameter int T_WALK     = 8,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    traffic_light_controller_if.slave   tl
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6,
        EMERG     = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] L_GREEN_NS = CNT_W'(T_GREEN_NS);
    localparam logic [CNT_W-1:0] L_GREEN_EW = CNT_W'(T_GREEN_EW);
    localparam logic [CNT_W-1:0] L_YELLOW   = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] L_ALLRED   = CNT_W'(T_ALLRED);
    localparam logic [CNT_W-1:0] L_WALK     = CNT_W'(T_WALK);
    localparam logic [CNT_W-1:0] C_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             r_ped_pending;
    logic             w_ped_nxt;
    logic [2:0]       r_ns_light;
    logic [2:0]       r_ew_light;
    logic             r_walk;
    logic [2:0]       w_ns_nxt;
    logic [2:0]       w_ew_nxt;
    logic             w_walk_nxt;
    logic             w_done;
    logic             w_entering;

    function automatic logic [CNT_W-1:0] f_duration(input state_t s);
        logic [CNT_W-1:0] d;
        case (s)
            NS_GREEN:  d = L_GREEN_NS;
            NS_YELLOW: d = L_YELLOW;
            ALLRED_A:  d = L_ALLRED;
            EW_GREEN:  d = L_GREEN_EW;
            EW_YELLOW: d = L_YELLOW;
            ALLRED_B:  d = L_ALLRED;
            PED_WALK:  d = L_WALK;
            default:   d = C_ONE;
        endcase
        return d;
    endfunction

    assign w_done     = tl.tick && (r_timer == C_ONE);
    assign w_entering = (w_state_nxt != r_state);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            NS_GREEN: begin
                // Minimum green: the timer parks at 1 until there is demand on a tick.
                if (tl.emerg || (w_done && (tl.sensor_ew || r_ped_pending)))
                    w_state_nxt = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (w_done)
                    w_state_nxt = ALLRED_A;
            end
            ALLRED_A: begin
                if (w_done) begin
                    if (tl.emerg)
                        w_state_nxt = EMERG;
                    else if (r_ped_pending)
                        w_state_nxt = PED_WALK;
                    else
                        w_state_nxt = EW_GREEN;
                end
            end
            PED_WALK: begin
                if (tl.emerg)
                    w_state_nxt = ALLRED_B;
                else if (w_done)
                    w_state_nxt = EW_GREEN;
            end
            EW_GREEN: begin
                if (tl.emerg || w_done)
                    w_state_nxt = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (w_done)
                    w_state_nxt = ALLRED_B;
            end
            ALLRED_B: begin
                if (w_done)
                    w_state_nxt = tl.emerg ? EMERG : NS_GREEN;
            end
            EMERG: begin
                if (!tl.emerg)
                    w_state_nxt = ALLRED_B;
            end
            default: w_state_nxt = ALLRED_B;
        endcase
    end

    always_comb begin
        w_timer_nxt = r_timer;
        if (w_entering)
            w_timer_nxt = f_duration(w_state_nxt);
        else if (tl.tick && (r_timer > C_ONE))
            w_timer_nxt = r_timer - C_ONE;
    end

    // Entering the walk phase serves the request, so the clear beats a same-cycle press.
    always_comb begin
        w_ped_nxt = r_ped_pending || (tl.ped_req && (r_state != PED_WALK));
        if (w_entering && (w_state_nxt == PED_WALK))
            w_ped_nxt = 1'b0;
    end

    always_comb begin
        w_ns_nxt   = LAMP_R;
        w_ew_nxt   = LAMP_R;
        w_walk_nxt = 1'b0;
        case (w_state_nxt)
            NS_GREEN:  w_ns_nxt   = LAMP_G;
            NS_YELLOW: w_ns_nxt   = LAMP_Y;
            EW_GREEN:  w_ew_nxt   = LAMP_G;
            EW_YELLOW: w_ew_nxt   = LAMP_Y;
            PED_WALK:  w_walk_nxt = 1'b1;
            default:   w_walk_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ALLRED_B;
            r_timer       <= L_ALLRED;
            r_ped_pending <= 1'b0;
            r_ns_light    <= LAMP_R;
            r_ew_light    <= LAMP_R;
            r_walk        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_ped_pending <= w_ped_nxt;
            r_ns_light    <= w_ns_nxt;
            r_ew_light    <= w_ew_nxt;
            r_walk        <= w_walk_nxt;
        end
    end

    assign tl.ns_light    = r_ns_light;
    assign tl.ew_light    = r_ew_light;
    assign tl.walk        = r_walk;
    assign tl.ped_pending = r_ped_pending;
    assign tl.state_o     = r_state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: stimulus queues expected phase/dwell pairs, a negedge monitor
// closes each phase on a state change or reset and checks it against the queue.
module tb_traffic_light_controller;

    typedef struct {
        logic [2:0] st;
        int         dmin;
        int         dmax;
    } seg_t;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   tick_mode = 1;
    int   tick_div  = 0;
    seg_t sb_q[$];

    logic [2:0] mon_cur = 3'd5;
    int         mon_cnt = 0;

    traffic_light_controller_if tl_if();

    traffic_light_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tl    (tl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] st, input int dmin, input int dmax);
        seg_t e;
        e.st = st; e.dmin = dmin; e.dmax = dmax;
        sb_q.push_back(e);
    endtask

    function automatic logic [6:0] exp_out(input logic [2:0] s);
        case (s)
            3'd0:    return {3'b001, 3'b100, 1'b0};
            3'd1:    return {3'b010, 3'b100, 1'b0};
            3'd3:    return {3'b100, 3'b001, 1'b0};
            3'd4:    return {3'b100, 3'b010, 1'b0};
            3'd6:    return {3'b100, 3'b100, 1'b1};
            default: return {3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    task automatic close_seg();
        seg_t e;
        n_chk++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: phase %0d ended after %0d cycles, nothing expected", mon_cur, mon_cnt);
            return;
        end
        e = sb_q.pop_front();
        if (e.st != mon_cur) begin
            n_fail++;
            $display("FAIL seg_state: got state %0d, expected %0d (t=%0t)", mon_cur, e.st, $time);
        end
        n_chk++;
        if (mon_cnt < e.dmin || (e.dmax >= 0 && mon_cnt > e.dmax)) begin
            n_fail++;
            $display("FAIL seg_dwell: state %0d lasted %0d cycles, expected %0d..%0d (t=%0t)",
                     mon_cur, mon_cnt, e.dmin, e.dmax, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] eo;
        if (!rst_n) begin
            if (mon_cnt > 0) close_seg();
            mon_cur = 3'd5;
            mon_cnt = 0;
        end else if (tl_if.state_o != mon_cur) begin
            close_seg();
            if (tl_if.state_o == 3'd0)
                chk("no_ew_to_ns_direct", int'(mon_cur == 3'd3 || mon_cur == 3'd4), 0);
            if (tl_if.state_o == 3'd3)
                chk("no_ns_to_ew_direct", int'(mon_cur == 3'd0 || mon_cur == 3'd1), 0);
            mon_cur = tl_if.state_o;
            mon_cnt = 1;
        end else begin
            mon_cnt++;
        end
        eo = exp_out(tl_if.state_o);
        chk("ns_light", int'(tl_if.ns_light), int'(eo[6:4]));
        chk("ew_light", int'(tl_if.ew_light), int'(eo[3:1]));
        chk("walk",     int'(tl_if.walk),     int'(eo[0]));
        chk("both_nonred", int'(tl_if.ns_light != 3'b100 && tl_if.ew_light != 3'b100), 0);
        if (tl_if.walk)
            chk("walk_all_red", int'(tl_if.ns_light == 3'b100 && tl_if.ew_light == 3'b100), 1);
        if (tl_if.state_o == 3'd6)
            chk("ped_clear_in_walk", int'(tl_if.ped_pending), 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tick_mode == 1) begin
            tl_if.tick = 1'b1;
        end else begin
            tick_div   = (tick_div == 2) ? 0 : tick_div + 1;
            tl_if.tick = (tick_div == 2);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tl_if.state_o == s) return;
            step();
        end
        chk("wait_state_timeout", int'(tl_if.state_o), int'(s));
    endtask

    task automatic chk_reset_now();
        chk("rst_state",   int'(tl_if.state_o),     5);
        chk("rst_ns",      int'(tl_if.ns_light),    4);
        chk("rst_ew",      int'(tl_if.ew_light),    4);
        chk("rst_walk",    int'(tl_if.walk),        0);
        chk("rst_ped",     int'(tl_if.ped_pending), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        tl_if.tick      = 1'b1;
        tl_if.sensor_ew = 1'b0;
        tl_if.ped_req   = 1'b0;
        tl_if.emerg     = 1'b0;

        // No demand: short clearance then an unbounded main green.
        push(3'd5, 2, 2);
        push(3'd0, 101, -1);
        cyc(2);
        rst_n = 1'b1;
        wait_state(3'd0, 10);
        cyc(120);
        chk("ns_green_hold", int'(tl_if.ns_light), 1);

        // Continuous side-road demand: one full cycle, then a pedestrian pulse.
        rst_n = 1'b0;
        tl_if.sensor_ew = 1'b1;
        #1;
        chk_reset_now();
        push(3'd5, 2, 2);   push(3'd0, 20, 20); push(3'd1, 4, 4);
        push(3'd2, 2, 2);   push(3'd3, 10, 10); push(3'd4, 4, 4);
        push(3'd5, 2, 2);   push(3'd0, 20, 20); push(3'd1, 4, 4);
        push(3'd2, 2, 2);   push(3'd6, 8, 8);   push(3'd3, 10, 10);
        push(3'd4, 4, 4);   push(3'd5, 2, 2);   push(3'd0, 20, 20);
        cyc(2);
        rst_n = 1'b1;
        wait_state(3'd3, 100);
        wait_state(3'd0, 100);
        tl_if.sensor_ew = 1'b0;
        cyc(5);
        tl_if.ped_req = 1'b1;
        cyc(1);
        tl_if.ped_req = 1'b0;
        chk("ped_latched", int'(tl_if.ped_pending), 1);
        wait_state(3'd6, 100);
        cyc(3);
        tl_if.ped_req = 1'b1;
        cyc(1);
        tl_if.ped_req = 1'b0;
        chk("ped_ignored_in_walk", int'(tl_if.ped_pending), 0);
        wait_state(3'd3, 100);
        chk("ped_after_walk", int'(tl_if.ped_pending), 0);

        // Emergency raised on the fifth tick of EW green.
        wait_state(3'd0, 100);
        tl_if.sensor_ew = 1'b1;
        push(3'd1, 4, 4);   push(3'd2, 2, 2);   push(3'd3, 5, 5);
        push(3'd4, 4, 4);   push(3'd5, 2, 2);   push(3'd7, 24, 24);
        push(3'd5, 2, 2);   push(3'd0, 20, 20);
        wait_state(3'd3, 100);
        tl_if.sensor_ew = 1'b0;
        cyc(4);
        tl_if.emerg = 1'b1;
        cyc(30);
        chk("emerg_hold", int'(tl_if.state_o), 7);
        tl_if.emerg = 1'b0;

        // Emergency during the walk phase.
        wait_state(3'd0, 20);
        tl_if.ped_req = 1'b1;
        cyc(1);
        tl_if.ped_req = 1'b0;
        push(3'd1, 4, 4);   push(3'd2, 2, 2);   push(3'd6, 3, 3);
        push(3'd5, 2, 2);   push(3'd7, 8, 8);   push(3'd5, 2, 2);
        push(3'd0, 60, 60);
        wait_state(3'd6, 100);
        cyc(2);
        tl_if.emerg = 1'b1;
        step();
        chk("emerg_walk_drop", int'(tl_if.walk), 0);
        chk("emerg_walk_state", int'(tl_if.state_o), 5);
        cyc(9);
        chk("emerg_walk_hold", int'(tl_if.state_o), 7);
        tl_if.emerg = 1'b0;
        chk("emerg_walk_ped", int'(tl_if.ped_pending), 0);

        // Tick every third clock, then an async reset partway through NS yellow.
        wait_state(3'd0, 50);
        tick_mode = 3;
        tick_div  = 0;
        tl_if.tick = 1'b0;
        tl_if.sensor_ew = 1'b1;
        cyc(2);
        tl_if.ped_req = 1'b1;
        cyc(1);
        tl_if.ped_req = 1'b0;
        push(3'd1, 5, 5);
        push(3'd5, 6, 6);   push(3'd0, 60, 60); push(3'd1, 12, 12);
        push(3'd2, 6, 6);
        wait_state(3'd1, 200);
        chk("ped_before_reset", int'(tl_if.ped_pending), 1);
        cyc(5);
        rst_n = 1'b0;
        #1;
        chk_reset_now();
        cyc(2);
        rst_n = 1'b1;
        tick_div   = 0;
        tl_if.tick = 1'b0;
        wait_state(3'd3, 300);
        cyc(2);
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
